// File: rtl/pci_pkg.sv
// Shared PCI definitions: bus command codes, target address and the
// arbiter state encoding used by pci_arbiter.
package pci_pkg;

    localparam logic [3:0]  PCI_read    = 4'b0010;
    localparam logic [3:0]  PCI_write   = 4'b0011;
    localparam logic [31:0] TARGET_ADDR = 32'h0000_1000;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_GRANT = 2'b01;
    localparam logic [1:0] ST_BUSY  = 2'b10;
    localparam logic [1:0] ST_TURN  = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        GRANT = ST_GRANT,
        BUSY  = ST_BUSY,
        TURN  = ST_TURN
    } arb_state_e;

    // FRAME# and IRDY# both deasserted means nobody is driving a transaction.
    function automatic logic is_bus_idle(input logic frame, input logic irdy);
        return frame & irdy;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: returns the first asserted request
// found scanning last+1, last+2, ... with wrap-around.
module rr_picker #(
    parameter int N  = 4,
    parameter int LW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [LW-1:0] last,
    output logic [LW-1:0] winner,
    output logic          valid
);

    logic [LW-1:0] idx_s;

    // Scan offsets 1..N after last; the earliest hit is kept.
    always_comb begin
        winner = {LW{1'b0}};
        valid  = 1'b0;
        idx_s  = {LW{1'b0}};
        for (int i = 1; i <= N; i++) begin
            idx_s = LW'((int'(last) + i) % N);
            if (req[idx_s] && !valid) begin
                winner = idx_s;
                valid  = 1'b1;
            end else begin
                valid  = valid;
            end
        end
    end

endmodule

// File: rtl/pci_arbiter.sv
// Central PCI bus arbiter: round-robin grant issue, FRAME#/IRDY# ownership
// tracking, mandatory turnaround and revocation of unused grants.
module pci_arbiter
    import pci_pkg::*;
#(
    parameter int N_MASTERS   = 4,
    parameter int GNT_TIMEOUT = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_MASTERS-1:0]         REQ_n,
    input  logic                         Frame,
    input  logic                         IRDY,
    output logic [N_MASTERS-1:0]         GNT_n,
    output logic [$clog2(N_MASTERS)-1:0] owner,
    output logic                         owner_valid,
    output logic                         bus_busy,
    output logic                         timeout
);

    localparam int OW = $clog2(N_MASTERS);
    localparam int CW = $clog2(GNT_TIMEOUT + 1);
    localparam logic [CW-1:0]        CNT_LAST  = CW'(GNT_TIMEOUT - 1);
    localparam logic [OW-1:0]        LAST_INIT = OW'(N_MASTERS - 1);
    localparam logic [N_MASTERS-1:0] GNT_NONE  = {N_MASTERS{1'b1}};

    logic [1:0]           state_r;
    logic [OW-1:0]        last_r;
    logic [CW-1:0]        cnt_r;
    logic [N_MASTERS-1:0] req_s;
    logic [OW-1:0]        winner_s;
    logic                 winner_valid_s;
    logic [N_MASTERS-1:0] grant_vec_s;
    logic                 bus_idle_s;

    assign req_s      = ~REQ_n;
    assign bus_idle_s = is_bus_idle(Frame, IRDY);

    rr_picker #(
        .N  (N_MASTERS),
        .LW (OW)
    ) u_picker (
        .req    (req_s),
        .last   (last_r),
        .winner (winner_s),
        .valid  (winner_valid_s)
    );

    // Active-low one-cold grant vector for the current winner.
    always_comb begin
        grant_vec_s = GNT_NONE;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (winner_s == OW'(i)) begin
                grant_vec_s[i] = 1'b0;
            end else begin
                grant_vec_s[i] = 1'b1;
            end
        end
    end

    // Arbitration FSM; every output is registered here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            last_r      <= LAST_INIT;
            cnt_r       <= {CW{1'b0}};
            GNT_n       <= GNT_NONE;
            owner       <= {OW{1'b0}};
            owner_valid <= 1'b0;
            bus_busy    <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            timeout <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (!Frame) begin
                        // Someone without a grant started a cycle: track it, own nothing.
                        state_r     <= ST_BUSY;
                        GNT_n       <= GNT_NONE;
                        owner_valid <= 1'b0;
                        bus_busy    <= 1'b1;
                    end else if (winner_valid_s) begin
                        state_r     <= ST_GRANT;
                        GNT_n       <= grant_vec_s;
                        owner       <= winner_s;
                        owner_valid <= 1'b1;
                        cnt_r       <= {CW{1'b0}};
                    end else begin
                        GNT_n       <= GNT_NONE;
                        owner_valid <= 1'b0;
                    end
                end
                ST_GRANT: begin
                    if (!Frame) begin
                        state_r  <= ST_BUSY;
                        GNT_n    <= GNT_NONE;
                        last_r   <= owner;
                        bus_busy <= 1'b1;
                    end else if (REQ_n[owner]) begin
                        state_r     <= ST_IDLE;
                        GNT_n       <= GNT_NONE;
                        owner_valid <= 1'b0;
                    end else if (cnt_r == CNT_LAST) begin
                        state_r     <= ST_IDLE;
                        GNT_n       <= GNT_NONE;
                        last_r      <= owner;
                        owner_valid <= 1'b0;
                        timeout     <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                ST_BUSY: begin
                    GNT_n <= GNT_NONE;
                    if (bus_idle_s) begin
                        state_r     <= ST_TURN;
                        owner_valid <= 1'b0;
                        bus_busy    <= 1'b0;
                    end else begin
                        bus_busy <= 1'b1;
                    end
                end
                ST_TURN: begin
                    state_r     <= ST_IDLE;
                    GNT_n       <= GNT_NONE;
                    owner_valid <= 1'b0;
                    bus_busy    <= 1'b0;
                end
                default: begin
                    state_r     <= ST_IDLE;
                    GNT_n       <= GNT_NONE;
                    owner_valid <= 1'b0;
                    bus_busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pci_arbiter.sv
// Self-checking bench for pci_arbiter: vector table, corner-case sequences
// and a randomized run compared against a behavioural reference model.
`timescale 1ns/1ps
module tb_pci_arbiter;

    localparam int N  = 4;
    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] REQ_n;
    logic       Frame;
    logic       IRDY;
    logic [3:0] GNT_n;
    logic [1:0] owner;
    logic       owner_valid;
    logic       bus_busy;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    // Reference model: who holds the grant, whether a transaction is on the
    // bus, whether the turnaround clock is pending, and the fairness pointer.
    int m_holder;
    int m_last;
    int m_owner;
    int m_wait;
    bit m_ov;
    bit m_on_bus;
    bit m_cool;
    bit m_to;
    logic [3:0] prev_gnt;

    typedef struct packed {
        logic [3:0] rq;
        logic       fr;
        logic       ir;
        logic [3:0] gnt;
        logic [1:0] own;
        logic       ov;
        logic       busy;
        logic       to;
    } vec_t;

    vec_t       vecs [21];
    logic [3:0] r_rq;
    int         lo_cnt;
    int         tp_cnt;
    bit         found;
    int         rr_exp [5];

    pci_arbiter #(
        .N_MASTERS   (N),
        .GNT_TIMEOUT (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .REQ_n       (REQ_n),
        .Frame       (Frame),
        .IRDY        (IRDY),
        .GNT_n       (GNT_n),
        .owner       (owner),
        .owner_valid (owner_valid),
        .bus_busy    (bus_busy),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_holder = -1;
        m_last   = N - 1;
        m_owner  = 0;
        m_wait   = 0;
        m_ov     = 1'b0;
        m_on_bus = 1'b0;
        m_cool   = 1'b0;
        m_to     = 1'b0;
        prev_gnt = 4'b1111;
    endtask

    task automatic model_step(input logic [3:0] rq, input logic fr, input logic ir);
        int c;
        m_to = 1'b0;
        if (m_cool) begin
            m_cool = 1'b0;
        end else if (m_on_bus) begin
            if (fr && ir) begin
                m_on_bus = 1'b0;
                m_cool   = 1'b1;
                m_ov     = 1'b0;
            end
        end else if (m_holder >= 0) begin
            if (!fr) begin
                m_last   = m_holder;
                m_holder = -1;
                m_on_bus = 1'b1;
            end else if (rq[2'(m_holder)]) begin
                m_holder = -1;
                m_ov     = 1'b0;
            end else if (m_wait == TO - 1) begin
                m_last   = m_holder;
                m_holder = -1;
                m_ov     = 1'b0;
                m_to     = 1'b1;
            end else begin
                m_wait++;
            end
        end else if (!fr) begin
            m_on_bus = 1'b1;
            m_ov     = 1'b0;
        end else begin
            for (int k = 1; k <= N; k++) begin
                c = (m_last + k) % N;
                if (!rq[2'(c)] && m_holder < 0) begin
                    m_holder = c;
                    m_owner  = c;
                    m_ov     = 1'b1;
                    m_wait   = 0;
                end
            end
        end
    endtask

    task automatic check_model();
        logic [3:0] eg;
        eg = (m_holder < 0) ? 4'b1111 : (4'b1111 ^ (4'b0001 << m_holder));
        chk("gnt_n", int'(GNT_n), int'(eg));
        chk("owner", int'(owner), m_owner);
        chk("owner_valid", int'(owner_valid), int'(m_ov));
        chk("bus_busy", int'(bus_busy), int'(m_on_bus));
        chk("timeout", int'(timeout), int'(m_to));
        chk("gnt_onehot", ($countones(~GNT_n) <= 1) ? 1 : 0, 1);
        chk("gnt_gap", (prev_gnt != 4'b1111 && GNT_n != 4'b1111 && prev_gnt != GNT_n) ? 1 : 0, 0);
        prev_gnt = GNT_n;
    endtask

    // Drive inputs, let the DUT and the model take the same edge, then sample.
    task automatic tick(input logic [3:0] rq, input logic fr, input logic ir);
        REQ_n = rq;
        Frame = fr;
        IRDY  = ir;
        @(posedge clk);
        model_step(rq, fr, ir);
        #1;
    endtask

    task automatic cycle(input logic [3:0] rq, input logic fr, input logic ir);
        tick(rq, fr, ir);
        check_model();
    endtask

    task automatic apply_reset();
        rst   = 1'b1;
        REQ_n = 4'b1111;
        Frame = 1'b1;
        IRDY  = 1'b1;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("reset_gnt", int'(GNT_n), 15);
        chk("reset_owner", int'(owner), 0);
        chk("reset_ov", int'(owner_valid), 0);
        chk("reset_busy", int'(bus_busy), 0);
        chk("reset_timeout", int'(timeout), 0);
        rst = 1'b0;
    endtask

    initial begin
        //          rq       fr    ir    gnt      own   ov    busy  to
        vecs[0]  = {4'b1111, 1'b1, 1'b1, 4'b1111, 2'd0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = {4'b1110, 1'b1, 1'b1, 4'b1110, 2'd0, 1'b1, 1'b0, 1'b0};
        vecs[2]  = {4'b1110, 1'b1, 1'b1, 4'b1110, 2'd0, 1'b1, 1'b0, 1'b0};
        vecs[3]  = {4'b1110, 1'b1, 1'b1, 4'b1110, 2'd0, 1'b1, 1'b0, 1'b0};
        vecs[4]  = {4'b1110, 1'b0, 1'b1, 4'b1111, 2'd0, 1'b1, 1'b1, 1'b0};
        vecs[5]  = {4'b1111, 1'b0, 1'b0, 4'b1111, 2'd0, 1'b1, 1'b1, 1'b0};
        vecs[6]  = {4'b1111, 1'b1, 1'b0, 4'b1111, 2'd0, 1'b1, 1'b1, 1'b0};
        vecs[7]  = {4'b1111, 1'b1, 1'b1, 4'b1111, 2'd0, 1'b0, 1'b0, 1'b0};
        vecs[8]  = {4'b1101, 1'b1, 1'b1, 4'b1111, 2'd0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = {4'b1101, 1'b1, 1'b1, 4'b1101, 2'd1, 1'b1, 1'b0, 1'b0};
        vecs[10] = {4'b1111, 1'b1, 1'b1, 4'b1111, 2'd1, 1'b0, 1'b0, 1'b0};
        vecs[11] = {4'b1100, 1'b1, 1'b1, 4'b1101, 2'd1, 1'b1, 1'b0, 1'b0};
        vecs[12] = {4'b1100, 1'b0, 1'b1, 4'b1111, 2'd1, 1'b1, 1'b1, 1'b0};
        vecs[13] = {4'b1100, 1'b1, 1'b1, 4'b1111, 2'd1, 1'b0, 1'b0, 1'b0};
        vecs[14] = {4'b1100, 1'b1, 1'b1, 4'b1111, 2'd1, 1'b0, 1'b0, 1'b0};
        vecs[15] = {4'b1100, 1'b1, 1'b1, 4'b1110, 2'd0, 1'b1, 1'b0, 1'b0};
        vecs[16] = {4'b1111, 1'b1, 1'b1, 4'b1111, 2'd0, 1'b0, 1'b0, 1'b0};
        vecs[17] = {4'b1111, 1'b0, 1'b1, 4'b1111, 2'd0, 1'b0, 1'b1, 1'b0};
        vecs[18] = {4'b1111, 1'b1, 1'b1, 4'b1111, 2'd0, 1'b0, 1'b0, 1'b0};
        vecs[19] = {4'b1111, 1'b1, 1'b1, 4'b1111, 2'd0, 1'b0, 1'b0, 1'b0};
        vecs[20] = {4'b1011, 1'b1, 1'b1, 4'b1011, 2'd2, 1'b1, 1'b0, 1'b0};

        // Vector table: single request, withdrawal, priority retention, foreign FRAME#.
        apply_reset();
        for (int v = 0; v < 21; v++) begin
            tick(vecs[v].rq, vecs[v].fr, vecs[v].ir);
            chk($sformatf("vec%0d_gnt", v), int'(GNT_n), int'(vecs[v].gnt));
            chk($sformatf("vec%0d_owner", v), int'(owner), int'(vecs[v].own));
            chk($sformatf("vec%0d_ov", v), int'(owner_valid), int'(vecs[v].ov));
            chk($sformatf("vec%0d_busy", v), int'(bus_busy), int'(vecs[v].busy));
            chk($sformatf("vec%0d_to", v), int'(timeout), int'(vecs[v].to));
        end

        // Round-robin with every master requesting and 3-clock transactions.
        apply_reset();
        rr_exp = '{0, 1, 2, 3, 0};
        for (int j = 0; j < 5; j++) begin
            found = 1'b0;
            for (int w = 0; w < 8; w++) begin
                cycle(4'b0000, 1'b1, 1'b1);
                if (GNT_n != 4'b1111) begin
                    found = 1'b1;
                    break;
                end
            end
            chk("rr_grant_seen", int'(found), 1);
            chk("rr_order", int'(owner), rr_exp[j]);
            chk("rr_gnt", int'(GNT_n), int'(4'b1111 ^ (4'b0001 << rr_exp[j])));
            cycle(4'b0000, 1'b0, 1'b1);
            cycle(4'b0000, 1'b0, 1'b0);
            cycle(4'b0000, 1'b1, 1'b0);
        end

        // Timeout: master 2 never starts; master 3 must be next.
        apply_reset();
        lo_cnt = 0;
        tp_cnt = 0;
        found  = 1'b0;
        for (int c = 0; c < 40; c++) begin
            cycle(4'b0011, 1'b1, 1'b1);
            if (GNT_n[2] == 1'b0) lo_cnt++;
            if (timeout) begin
                tp_cnt++;
                found = 1'b1;
                break;
            end
        end
        chk("to_seen", int'(found), 1);
        chk("to_grant_len", lo_cnt, 16);
        chk("to_gnt_at_pulse", int'(GNT_n), 15);
        cycle(4'b0011, 1'b1, 1'b1);
        chk("to_pulse_once", int'(timeout), 0);
        chk("to_next_gnt", int'(GNT_n), int'(4'b0111));
        chk("to_next_owner", int'(owner), 3);

        // FRAME# on the same edge the grant would expire: transaction accepted.
        apply_reset();
        cycle(4'b1110, 1'b1, 1'b1);
        for (int c = 0; c < TO - 1; c++) cycle(4'b1110, 1'b1, 1'b1);
        chk("sim_still_granted", int'(GNT_n), int'(4'b1110));
        cycle(4'b1110, 1'b0, 1'b1);
        chk("sim_busy", int'(bus_busy), 1);
        chk("sim_no_timeout", int'(timeout), 0);
        chk("sim_gnt", int'(GNT_n), 15);
        cycle(4'b1111, 1'b1, 1'b1);
        cycle(4'b1111, 1'b1, 1'b1);

        // Reset pulse while master 3 owns the bus.
        apply_reset();
        cycle(4'b0111, 1'b1, 1'b1);
        chk("rb_owner3", int'(owner), 3);
        cycle(4'b0111, 1'b0, 1'b1);
        chk("rb_busy", int'(bus_busy), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("rb_async_gnt", int'(GNT_n), 15);
        chk("rb_async_ov", int'(owner_valid), 0);
        chk("rb_async_busy", int'(bus_busy), 0);
        model_reset();
        #2;
        rst = 1'b0;
        cycle(4'b0000, 1'b1, 1'b1);
        chk("rb_first_gnt", int'(GNT_n), int'(4'b1110));
        chk("rb_first_owner", int'(owner), 0);

        // Randomized run: sticky requests, with FRAME#-free stretches to provoke timeouts.
        apply_reset();
        r_rq = 4'b1111;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 9) == 0) r_rq[b] = ~r_rq[b];
            end
            if ((cyc / 64) % 3 == 0) begin
                cycle(r_rq, 1'b1, 1'b1);
            end else begin
                cycle(r_rq, ($urandom_range(0, 5) != 0), 1'($urandom_range(0, 1)));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pci_arbiter.md
Name: pci_arbiter

Overview:
- Central PCI bus arbiter sharing the single AD/Frame/IRDY bus between up to N initiators.
- Samples each initiator's active-low request and issues one active-low grant, using round-robin fairness.
- Monitors Frame/IRDY to track bus ownership, and revokes grants that are never used.
- Sits beside the PCI target devices on the shared bus and runs on the same clk.

Parameters:
- N_MASTERS, 4, number of requesting initiators; legal range 2..8.
- GNT_TIMEOUT, 16, clocks a granted master may leave the bus idle before its grant is revoked; legal range 2..31.

Ports:
- clk  input  1  bus clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- REQ_n  input  N_MASTERS  per-master request, active low.
- Frame  input  1  PCI FRAME#, active low.
- IRDY  input  1  PCI IRDY#, active low.
- GNT_n  output  N_MASTERS  per-master grant, active low, registered.
- owner  output  clog2(N_MASTERS)  index of the granted or transacting master.
- owner_valid  output  1  high in GRANT and BUSY states.
- bus_busy  output  1  high in BUSY state.
- timeout  output  1  one-clock pulse when a grant is revoked for non-use.

Behaviour:
- Reset (async, immediate):
  - state = IDLE, GNT_n = all 1s, owner = 0, owner_valid = 0, bus_busy = 0, timeout = 0.
  - Round-robin pointer last = N_MASTERS-1, so master 0 has first priority.
  - Counter cnt = 0.
- Bus idle is defined as Frame == 1 && IRDY == 1, sampled at posedge.
- Winner selection: the first requesting master (REQ_n[i] == 0) scanning last+1, last+2, ... with wrap modulo N_MASTERS.
- States:
  - IDLE:
    - If any REQ_n is low: GNT_n[winner] = 0 (all other bits 1), owner = winner, cnt = 0, go to GRANT.
    - Otherwise stay in IDLE with GNT_n = all 1s. There is no bus parking.
  - GRANT, evaluated in priority order:
    - (a) Frame == 0 sampled: GNT_n = all 1s, last = owner, go to BUSY. The master now owns the bus until it goes idle.
    - (b) REQ_n[owner] == 1 (request withdrawn): GNT_n = all 1s, go to IDLE. last is unchanged.
    - (c) cnt == GNT_TIMEOUT-1: GNT_n = all 1s, last = owner, timeout = 1 for one clock, go to IDLE.
    - Otherwise: cnt++.
  - BUSY:
    - GNT_n stays all 1s.
    - When bus idle is sampled, go to TURN.
    - Requests arriving during BUSY are held by the masters and not latched.
  - TURN:
    - One mandatory turnaround clock with GNT_n = all 1s, then go to IDLE.
- Latency:
  - REQ_n low sampled at edge k in IDLE → GNT_n low visible after edge k.
  - Bus idle sampled at edge m → the earliest next grant is visible after edge m+2.
- Ownership-change invariants:
  - At most one GNT_n bit is ever low.
  - Between deasserting one grant and asserting another, there is always at least one clock with all GNT_n high.
- Simultaneous events in GRANT: Frame low together with REQ withdrawn or timeout → (a) wins; the transaction is accepted.
- Frame low in IDLE (a foreign or unexpected initiator): go to BUSY with owner_valid = 0 and last unchanged.
- A master that re-requests immediately after its transaction gets lower priority than all others, because the pointer has moved past it.
- rst asserted mid-BUSY or mid-GRANT: all grants drop at once and the FSM returns to IDLE. The in-flight transaction is abandoned; the bus drains by itself.
- cnt width is clog2(GNT_TIMEOUT+1) and cnt never wraps.

Decomposition:
- Shared package pci_pkg holds:
  - PCI command constants PCI_read = 4'b0010 and PCI_write = 4'b0011.
  - The target device address constant.
  - The arbiter state enum: IDLE, GRANT, BUSY, TURN.
- One combinational sub-module, rr_picker:
  - Inputs: req (active-high vector) and last.
  - Outputs: winner index and a valid flag.
  - Instantiated once inside pci_arbiter.

Test Plan:
- Single request: REQ_n = 4'b1110 at 100 ns, Frame low 2 clocks after GNT_n = 4'b1110 → BUSY, GNT_n = 4'b1111, owner = 0. After Frame/IRDY both high → TURN, then IDLE.
- Round-robin: all four REQ_n held low, each master runs a 3-clock transaction → grant order 0, 1, 2, 3, 0, with one all-high GNT_n clock between grants.
- Timeout: REQ_n[2] low, Frame never asserted → GNT_n[2] low for exactly 16 clocks, then timeout pulses once and the next grant goes to master 3 if it is requesting.
- Withdrawal: master 1 granted, REQ_n[1] raised before Frame → GNT_n all high the next clock, no timeout pulse, and master 1 keeps its priority.
- Simultaneous events: Frame low on the same edge that cnt reaches 15 → BUSY entered and no timeout pulse.
- Reset mid-BUSY: rst pulsed while owner = 3 → GNT_n = 4'b1111, owner_valid = 0, and master 0 is granted first afterwards.
